// File: rtl/myfilter_pkg.sv
// Shared filter-memory definitions: dmem depth and command encoding.
package myfilter_pkg;

    localparam int unsigned DMEMSIZE = 16;

    typedef enum logic [1:0] {
        DMEM_NOP     = 2'd0,
        DMEM_LOADEXT = 2'd1,
        DMEM_READ    = 2'd2,
        DMEM_WRITE   = 2'd3
    } dmem_cmd_t;

endpackage

// File: rtl/dmem_seq.sv
// dmem_seq: per-sample address/command sequencer for the filter delay line.
// Loads each accepted sample at the write pointer, then reads the TAPS newest
// samples (newest first) and emits MAC strobes aligned with dmem read data.
module dmem_seq
    import myfilter_pkg::*;
#(
    parameter int unsigned TAPS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    output logic                        ready_out,
    output dmem_cmd_t                   cmd_out,
    output logic [$clog2(DMEMSIZE)-1:0] addr_out,
    output logic [$clog2(TAPS)-1:0]     tap_out,
    output logic                        mac_clr_out,
    output logic                        mac_en_out,
    output logic                        done_out
);

    localparam int unsigned AW = $clog2(DMEMSIZE);
    localparam int unsigned KW = $clog2(TAPS);
    localparam int unsigned SW = KW + 1;

    localparam logic [KW-1:0] LAST_K = KW'(TAPS - 1);
    localparam logic [SW-1:0] TAPS_S = SW'(TAPS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_wptr;
    logic [KW-1:0]   r_k;
    logic            r_ready;
    dmem_cmd_t       r_cmd;
    logic [AW-1:0]   r_addr;
    logic [KW-1:0]   r_tap;
    logic            r_mac_clr;
    logic            r_mac_en;
    logic            r_done;

    logic [KW-1:0]   w_k_next;
    logic [KW-1:0]   w_rd_addr;
    logic [KW-1:0]   w_wptr_inc;

    // (a - b) mod TAPS: one extra bit catches the borrow, then TAPS is added back
    function automatic logic [KW-1:0] mod_sub(input logic [KW-1:0] a, input logic [KW-1:0] b);
        logic [SW-1:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[KW]) begin
            d = d + TAPS_S;
        end
        return d[KW-1:0];
    endfunction

    // Next read index, its circular address, and the wrapped pointer increment
    always_comb begin
        w_k_next   = r_k + KW'(1);
        w_rd_addr  = mod_sub(r_wptr, w_k_next);
        w_wptr_inc = (r_wptr == LAST_K) ? '0 : r_wptr + KW'(1);
    end

    // Sequencer FSM; every output is a register loaded with its next-cycle value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_k       <= '0;
            r_ready   <= 1'b1;
            r_cmd     <= DMEM_NOP;
            r_addr    <= '0;
            r_tap     <= '0;
            r_mac_clr <= 1'b0;
            r_mac_en  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mac_en  <= 1'b0;
                    r_mac_clr <= 1'b0;
                    r_tap     <= '0;
                    r_done    <= 1'b0;
                    if (valid_in) begin
                        r_state <= S_LOAD;
                        r_ready <= 1'b0;
                        r_cmd   <= DMEM_LOADEXT;
                        r_addr  <= AW'(r_wptr);
                    end else begin
                        r_ready <= 1'b1;
                        r_cmd   <= DMEM_NOP;
                        r_addr  <= '0;
                    end
                end

                S_LOAD: begin
                    // First read targets the slot just written (k = 0)
                    r_state <= S_READ;
                    r_k     <= '0;
                    r_cmd   <= DMEM_READ;
                    r_addr  <= AW'(r_wptr);
                end

                S_READ: begin
                    // Strobes for this read land with its data one cycle later
                    r_mac_en  <= 1'b1;
                    r_tap     <= r_k;
                    r_mac_clr <= (r_k == '0);
                    if (r_k == LAST_K) begin
                        r_state <= S_DRAIN;
                        r_k     <= '0;
                        r_cmd   <= DMEM_NOP;
                        r_addr  <= '0;
                    end else begin
                        r_k    <= w_k_next;
                        r_addr <= AW'(w_rd_addr);
                    end
                end

                S_DRAIN: begin
                    r_state   <= S_DONE;
                    r_mac_en  <= 1'b0;
                    r_mac_clr <= 1'b0;
                    r_tap     <= '0;
                    r_done    <= 1'b1;
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_wptr  <= w_wptr_inc;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_k       <= '0;
                    r_ready   <= 1'b1;
                    r_cmd     <= DMEM_NOP;
                    r_addr    <= '0;
                    r_tap     <= '0;
                    r_mac_clr <= 1'b0;
                    r_mac_en  <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out   = r_ready;
    assign cmd_out     = r_cmd;
    assign addr_out    = r_addr;
    assign tap_out     = r_tap;
    assign mac_clr_out = r_mac_clr;
    assign mac_en_out  = r_mac_en;
    assign done_out    = r_done;

endmodule

// File: tb/tb_dmem_seq.sv
// Bench for dmem_seq: TAPS=4 and TAPS=5 instances, each with a behavioural dmem,
// checked against a scoreboard of expected LOAD/READ addresses and MAC data.
module tb_dmem_seq;
    import myfilter_pkg::*;

    localparam int unsigned AW = $clog2(DMEMSIZE);

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] ext;
    int          sel;
    int          T;

    always #5 clk = ~clk;

    // TAPS = 4 instance
    logic          v4, rdy4, clr4, en4, done4;
    dmem_cmd_t     cmd4;
    logic [AW-1:0] addr4;
    logic [1:0]    tap4;
    // TAPS = 5 instance
    logic          v5, rdy5, clr5, en5, done5;
    dmem_cmd_t     cmd5;
    logic [AW-1:0] addr5;
    logic [2:0]    tap5;

    assign v4 = valid && (sel == 0);
    assign v5 = valid && (sel == 1);

    dmem_seq #(.TAPS(4)) u_dut4 (
        .clk(clk), .rst(rst), .valid_in(v4), .ready_out(rdy4), .cmd_out(cmd4),
        .addr_out(addr4), .tap_out(tap4), .mac_clr_out(clr4), .mac_en_out(en4),
        .done_out(done4)
    );

    dmem_seq #(.TAPS(5)) u_dut5 (
        .clk(clk), .rst(rst), .valid_in(v5), .ready_out(rdy5), .cmd_out(cmd5),
        .addr_out(addr5), .tap_out(tap5), .mac_clr_out(clr5), .mac_en_out(en5),
        .done_out(done5)
    );

    // Behavioural dmem per instance: write completes at the edge, read data next cycle
    logic [15:0] mem4 [DMEMSIZE] = '{default: '0};
    logic [15:0] mem5 [DMEMSIZE] = '{default: '0};
    logic [15:0] dout4 = '0;
    logic [15:0] dout5 = '0;

    always @(posedge clk) begin
        if (cmd4 == DMEM_LOADEXT) mem4[addr4] <= ext;
        else if (cmd4 == DMEM_READ) dout4 <= mem4[addr4];
        if (cmd5 == DMEM_LOADEXT) mem5[addr5] <= ext;
        else if (cmd5 == DMEM_READ) dout5 <= mem5[addr5];
    end

    // Observed view of the instance under test
    logic          o_rdy, o_clr, o_en, o_done;
    dmem_cmd_t     o_cmd;
    logic [AW-1:0] o_addr;
    logic [2:0]    o_tap;
    logic [15:0]   o_dout;

    always_comb begin
        if (sel == 0) begin
            o_rdy = rdy4; o_clr = clr4; o_en = en4; o_done = done4;
            o_cmd = cmd4; o_addr = addr4; o_tap = {1'b0, tap4}; o_dout = dout4;
            T = 4;
        end else begin
            o_rdy = rdy5; o_clr = clr5; o_en = en5; o_done = done5;
            o_cmd = cmd5; o_addr = addr5; o_tap = tap5; o_dout = dout5;
            T = 5;
        end
    end

    // Scoreboard
    typedef struct {
        int          tap;
        bit          clr;
        logic [15:0] data;
    } mac_t;

    int          q_load [$];
    int          q_read [$];
    mac_t        q_mac  [$];
    logic [15:0] ref_mem [2][DMEMSIZE] = '{default: '0};
    int          wptr_m [2];
    int          done_cnt;
    bit          mon_en;
    int          n_checks;
    int          n_fail;
    int          e_addr;
    mac_t        e_mac;

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_cmd == DMEM_LOADEXT) begin
                n_checks++;
                if (q_load.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_load: unexpected LOADEXT at addr %0d, none expected", o_addr);
                end else begin
                    e_addr = q_load.pop_front();
                    if (int'(o_addr) !== e_addr) begin
                        n_fail++;
                        $display("FAIL sb_load: addr %0d, expected %0d", o_addr, e_addr);
                    end
                end
            end
            if (o_cmd == DMEM_READ) begin
                n_checks++;
                if (q_read.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_read: unexpected READ at addr %0d, none expected", o_addr);
                end else begin
                    e_addr = q_read.pop_front();
                    if (int'(o_addr) !== e_addr) begin
                        n_fail++;
                        $display("FAIL sb_read: addr %0d, expected %0d", o_addr, e_addr);
                    end
                end
            end
            if (o_en === 1'b1) begin
                n_checks++;
                if (q_mac.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_mac: unexpected mac_en tap %0d, none expected", o_tap);
                end else begin
                    e_mac = q_mac.pop_front();
                    if (int'(o_tap) !== e_mac.tap || o_clr !== e_mac.clr || o_dout !== e_mac.data) begin
                        n_fail++;
                        $display("FAIL sb_mac: tap %0d clr %0b data %h, expected tap %0d clr %0b data %h",
                                 o_tap, o_clr, o_dout, e_mac.tap, e_mac.clr, e_mac.data);
                    end
                end
            end
            if (o_done === 1'b1) done_cnt++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Record the expected LOAD/READ/MAC sequence for one accepted sample
    task automatic push_sample(input logic [15:0] val);
        int w;
        int a;
        w = wptr_m[sel];
        q_load.push_back(w);
        ref_mem[sel][w] = val;
        for (int k = 0; k < T; k++) begin
            a = ((w - k) % T + T) % T;
            q_read.push_back(a);
            q_mac.push_back('{tap: k, clr: (k == 0), data: ref_mem[sel][a]});
        end
        wptr_m[sel] = (w + 1) % T;
    endtask

    task automatic flush_sb();
        q_load.delete();
        q_read.delete();
        q_mac.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        flush_sb();
        wptr_m[sel] = 0;
        done_cnt = 0;
    endtask

    task automatic check_sb_empty(input string name, input int exp_done);
        n_checks++;
        if (q_load.size() != 0 || q_read.size() != 0 || q_mac.size() != 0 || done_cnt != exp_done) begin
            n_fail++;
            $display("FAIL %s_end: pending load %0d read %0d mac %0d done %0d, expected 0 0 0 done %0d",
                     name, q_load.size(), q_read.size(), q_mac.size(), done_cnt, exp_done);
        end
    endtask

    // Stream of n back-to-back samples with valid held high; ready only on accept cycles
    task automatic run_stream(input string name, input int n, input logic [15:0] base);
        valid = 1'b1;
        for (int s = 0; s < n; s++) begin
            ext = base + 16'(s);
            push_sample(ext);
            for (int c = 0; c < T + 4; c++) begin
                if (s == n - 1 && c == T + 3) valid = 1'b0;
                @(negedge clk);
                n_checks++;
                if (o_rdy !== (c == 0)) begin
                    n_fail++;
                    $display("FAIL %s_ready: sample %0d cycle %0d ready %b, expected %b",
                             name, s, c, o_rdy, (c == 0));
                end
                next_cycle();
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_rdy !== 1'b1 || o_cmd !== DMEM_NOP) begin
                n_fail++;
                $display("FAIL %s_idle: ready %b cmd %0d, expected 1 %0d", name, o_rdy, o_cmd, DMEM_NOP);
            end
            next_cycle();
        end
        check_sb_empty(name, n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (o_rdy !== 1'b1 || o_cmd !== DMEM_NOP || o_addr !== '0 || o_tap !== '0 ||
                o_clr !== 1'b0 || o_en !== 1'b0 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: rdy %b cmd %0d addr %0d tap %0d clr %b en %b done %b, expected 1 0 0 0 0 0 0",
                         o_rdy, o_cmd, o_addr, o_tap, o_clr, o_en, o_done);
            end
            next_cycle();
        end
        n_checks++;
        if (rdy5 !== 1'b1 || cmd5 !== DMEM_NOP || en5 !== 1'b0 || done5 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut5: rdy %b cmd %0d en %b done %b, expected 1 0 0 0", rdy5, cmd5, en5, done5);
        end
        wptr_m[0] = 0;
        wptr_m[1] = 0;
        done_cnt  = 0;
        mon_en    = 1'b1;
    endtask

    task automatic test_single();
        dmem_cmd_t e_cmd;
        bit        e_en, e_clr, e_done, e_rdy;
        sel = 0;
        done_cnt = 0;
        valid = 1'b1;
        ext = 16'hA001;
        push_sample(ext);
        @(negedge clk);
        n_checks++;
        if (o_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: ready %b, expected 1", o_rdy);
        end
        next_cycle();
        valid = 1'b0;
        for (int c = 1; c <= T + 5; c++) begin
            e_cmd  = (c == 1) ? DMEM_LOADEXT : ((c >= 2 && c <= T + 1) ? DMEM_READ : DMEM_NOP);
            e_en   = (c >= 3 && c <= T + 2);
            e_clr  = (c == 3);
            e_done = (c == T + 3);
            e_rdy  = (c >= T + 4);
            @(negedge clk);
            n_checks++;
            if (o_cmd !== e_cmd || o_en !== e_en || o_clr !== e_clr || o_done !== e_done ||
                o_rdy !== e_rdy || (e_en && int'(o_tap) != c - 3) || (c == 1 && o_addr !== '0)) begin
                n_fail++;
                $display("FAIL single_cycle%0d: cmd %0d en %b clr %b done %b rdy %b tap %0d addr %0d, expected cmd %0d en %b clr %b done %b rdy %b tap %0d",
                         c, o_cmd, o_en, o_clr, o_done, o_rdy, o_tap, o_addr,
                         e_cmd, e_en, e_clr, e_done, e_rdy, e_en ? c - 3 : 0);
            end
            next_cycle();
        end
        check_sb_empty("single", 1);
    endtask

    task automatic test_back_to_back();
        sel = 0;
        do_reset();
        run_stream("b2b4", 5, 16'hB000);
    endtask

    task automatic test_reset_mid();
        sel = 0;
        done_cnt = 0;
        valid = 1'b1;
        ext = 16'hC0DE;
        push_sample(ext);
        next_cycle();
        valid = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        flush_sb();
        wptr_m[0] = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_rdy !== 1'b1 || o_cmd !== DMEM_NOP || o_en !== 1'b0 || o_clr !== 1'b0 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_idle%0d: rdy %b cmd %0d en %b clr %b done %b, expected 1 0 0 0 0",
                         c, o_rdy, o_cmd, o_en, o_clr, o_done);
            end
            next_cycle();
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: done pulses %0d, expected 0", done_cnt);
        end
        valid = 1'b1;
        ext = 16'hD00D;
        push_sample(ext);
        next_cycle();
        valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_cmd !== DMEM_LOADEXT || o_addr !== '0) begin
            n_fail++;
            $display("FAIL rstmid_load: cmd %0d addr %0d, expected %0d 0", o_cmd, o_addr, DMEM_LOADEXT);
        end
        repeat (T + 5) next_cycle();
        check_sb_empty("rstmid", 1);
    endtask

    task automatic test_taps5();
        sel = 1;
        do_reset();
        run_stream("taps5", 7, 16'hE100);
        sel = 0;
    endtask

    initial begin
        sel      = 0;
        valid    = 1'b0;
        ext      = '0;
        rst      = 1'b1;
        mon_en   = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_taps5();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
